// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the adder ring-oscillator measurement sequencer.
package adder_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_SETTLE  = 3'd3,
    S_RUN     = 3'd4,
    S_CAPTURE = 3'd5,
    S_NEXT    = 3'd6
  } state_e;

  localparam int unsigned CLEAR_CYCLES = 2;

  typedef logic [2:0] bit_idx_t;

  // A reversed range collapses to a single measurement of the first bit.
  function automatic bit_idx_t sweep_last_bit(bit_idx_t first, bit_idx_t last);
    return (first > last) ? first : last;
  endfunction

endpackage

// File: rtl/ring_bit_select.sv
// Decodes the bit under test into the active-low one-hot ring select.
module ring_bit_select
  import adder_seq_pkg::*;
(
  input  logic       en_i,
  input  logic [2:0] bit_i,
  output logic [7:0] sel_b_o
);

  bit_idx_t idx;

  always_comb begin
    idx     = bit_i;
    sel_b_o = 8'hFF;
    if (en_i) sel_b_o[idx] = 1'b0;
  end

endmodule

// File: rtl/adder_measure_sequencer.sv
// Sweeps adder bits, running each ring for a fixed integration window and capturing its count.
module adder_measure_sequencer
  import adder_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] integration_time_i,
  input  logic [2:0]       bit_first,
  input  logic [2:0]       bit_last,
  output logic             adder_reset,
  output logic             counter_load,
  output logic             counter_enable,
  output logic             stop_b,
  output logic [CNT_W-1:0] integration_time_o,
  output logic [7:0]       a_input_ring_bit_b,
  output logic [7:0]       s_output_bit_b,
  input  logic             done,
  input  logic [CNT_W-1:0] ring_count_i,
  output logic             result_valid,
  output logic [2:0]       result_bit,
  output logic [CNT_W-1:0] result_count,
  output logic             busy,
  output logic             sweep_done,
  output logic [2:0]       state_o
);

  // SETTLE_CYCLES must be at least 1.
  localparam logic [15:0] CLEAR_LAST  = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  bit_idx_t         cur_bit_q, cur_bit_d;
  bit_idx_t         last_bit_q, last_bit_d;
  logic [CNT_W-1:0] itime_q, itime_d;
  bit_idx_t         res_bit_q, res_bit_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [7:0]       sel_b;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_bit_q  <= '0;
      last_bit_q <= '0;
      itime_q    <= '0;
      res_bit_q  <= '0;
      res_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_bit_q  <= cur_bit_d;
      last_bit_q <= last_bit_d;
      itime_q    <= itime_d;
      res_bit_q  <= res_bit_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_bit_d  = cur_bit_q;
    last_bit_d = last_bit_q;
    itime_d    = itime_q;
    res_bit_d  = res_bit_q;
    res_cnt_d  = res_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          itime_d    = integration_time_i;
          cur_bit_d  = bit_first;
          last_bit_d = sweep_last_bit(bit_first, bit_last);
          cnt_d      = '0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CLEAR_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        if (done) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_bit_d = cur_bit_q;
        res_cnt_d = ring_count_i;
        state_d   = S_NEXT;
      end
      S_NEXT: begin
        if (cur_bit_q == last_bit_q) begin
          state_d = S_IDLE;
        end else begin
          cur_bit_d = cur_bit_q + 3'd1;
          cnt_d     = '0;
          state_d   = S_CLEAR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a capture in flight.
    if (abort) begin
      state_d   = S_IDLE;
      res_bit_d = res_bit_q;
      res_cnt_d = res_cnt_q;
    end
  end

  ring_bit_select u_sel (
    .en_i    (state_q != S_IDLE),
    .bit_i   (cur_bit_q),
    .sel_b_o (sel_b)
  );

  always_comb begin
    adder_reset    = (state_q == S_CLEAR);
    counter_load   = (state_q == S_LOAD);
    stop_b         = (state_q == S_SETTLE) || (state_q == S_RUN);
    counter_enable = (state_q == S_RUN);
    busy           = (state_q != S_IDLE);
    result_valid   = (state_q == S_NEXT) && !abort;
    sweep_done     = result_valid && (cur_bit_q == last_bit_q);
  end

  assign integration_time_o = itime_q;
  assign a_input_ring_bit_b = sel_b;
  assign s_output_bit_b     = sel_b;
  assign result_bit         = res_bit_q;
  assign result_count       = res_cnt_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench for adder_measure_sequencer with a result scoreboard.
module tb_adder_measure_sequencer;

  localparam int SETTLE = 4;
  localparam int CW     = 32;
  localparam int W      = 1 + 3 + CW;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_ni = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          done = 1'b0;
  logic [CW-1:0] integration_time_i = '0;
  logic [2:0]    bit_first = '0;
  logic [2:0]    bit_last = '0;
  logic [CW-1:0] ring_count_i = '0;
  logic          adder_reset, counter_load, counter_enable, stop_b;
  logic [CW-1:0] integration_time_o;
  logic [7:0]    a_input_ring_bit_b, s_output_bit_b;
  logic          result_valid, busy, sweep_done;
  logic [2:0]    result_bit;
  logic [CW-1:0] result_count;
  logic [2:0]    state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  adder_measure_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .wb_clk_i           (wb_clk_i),
    .wb_rst_ni          (wb_rst_ni),
    .start              (start),
    .abort              (abort),
    .integration_time_i (integration_time_i),
    .bit_first          (bit_first),
    .bit_last           (bit_last),
    .adder_reset        (adder_reset),
    .counter_load       (counter_load),
    .counter_enable     (counter_enable),
    .stop_b             (stop_b),
    .integration_time_o (integration_time_o),
    .a_input_ring_bit_b (a_input_ring_bit_b),
    .s_output_bit_b     (s_output_bit_b),
    .done               (done),
    .ring_count_i       (ring_count_i),
    .result_valid       (result_valid),
    .result_bit         (result_bit),
    .result_count       (result_count),
    .busy               (busy),
    .sweep_done         (sweep_done),
    .state_o            (state_o)
  );

  // Clock and watchdog
  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sel_of(input logic [2:0] b);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << b);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".adder_reset"}, adder_reset, 0);
    chk({tag, ".counter_load"}, counter_load, 0);
    chk({tag, ".counter_enable"}, counter_enable, 0);
    chk({tag, ".stop_b"}, stop_b, 0);
    chk({tag, ".sel_a"}, a_input_ring_bit_b, 8'hFF);
    chk({tag, ".sel_s"}, s_output_bit_b, 8'hFF);
    chk({tag, ".result_valid"}, result_valid, 0);
    chk({tag, ".sweep_done"}, sweep_done, 0);
  endtask

  // Driver tasks
  task automatic start_sweep(input logic [2:0] f, input logic [2:0] l, input logic [CW-1:0] t);
    integration_time_i = t;
    bit_first = f;
    bit_last  = l;
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    integration_time_i = $urandom;
  endtask

  // Entered on the first CLEAR cycle; returns on the first RUN cycle.
  task automatic to_run(input logic [2:0] b, input logic [CW-1:0] t, input bit done_in_settle);
    logic [7:0] s;
    s = sel_of(b);
    chk("clear1.adder_reset", adder_reset, 1);
    chk("clear1.busy", busy, 1);
    chk("clear1.sel_a", a_input_ring_bit_b, s);
    chk("clear1.sel_s", s_output_bit_b, s);
    chk("clear1.stop_b", stop_b, 0);
    @(negedge wb_clk_i);
    chk("clear2.adder_reset", adder_reset, 1);
    chk("clear2.counter_load", counter_load, 0);
    @(negedge wb_clk_i);
    chk("load.counter_load", counter_load, 1);
    chk("load.adder_reset", adder_reset, 0);
    chk("load.itime", integration_time_o, t);
    chk("load.stop_b", stop_b, 0);
    @(negedge wb_clk_i);
    if (done_in_settle) done = 1'b1;
    for (int i = 0; i < SETTLE; i++) begin
      chk("settle.stop_b", stop_b, 1);
      chk("settle.counter_enable", counter_enable, 0);
      chk("settle.counter_load", counter_load, 0);
      chk("settle.sel_a", a_input_ring_bit_b, s);
      @(negedge wb_clk_i);
    end
  endtask

  // Runs the RUN phase, raising done on the last cycle; returns in NEXT.
  task automatic finish_run(input logic [2:0] b, input logic [CW-1:0] cnt, input int run_cycles,
                            input logic last);
    logic [7:0] s;
    s = sel_of(b);
    for (int i = 1; i <= run_cycles; i++) begin
      chk("run.counter_enable", counter_enable, 1);
      chk("run.stop_b", stop_b, 1);
      chk("run.sel_s", s_output_bit_b, s);
      if (i == run_cycles) begin
        done = 1'b1;
        ring_count_i = cnt;
        exp_q.push_back({last, b, cnt});
      end
      @(negedge wb_clk_i);
    end
    done = 1'b0;
    chk("capture.counter_enable", counter_enable, 0);
    chk("capture.stop_b", stop_b, 0);
    chk("capture.busy", busy, 1);
    chk("capture.result_valid", result_valid, 0);
    @(negedge wb_clk_i);
    chk("next.busy", busy, 1);
    chk("next.sel_a", a_input_ring_bit_b, s);
    ring_count_i = $urandom;
  endtask

  // Scoreboard
  always @(negedge wb_clk_i) begin
    logic [W-1:0] e;
    if (result_valid) begin
      if (exp_q.size() == 0) begin
        chk("stray_result_valid", result_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result", {sweep_done, result_bit, result_count}, e);
      end
    end else if (sweep_done) begin
      chk("sweep_done_without_result", sweep_done, 0);
    end
  end

  initial begin
    logic [7:0] sel_tab[4];
    logic [CW-1:0] t;
    sel_tab = '{8'hFB, 8'hF7, 8'hEF, 8'hDF};

    // Reset
    repeat (3) @(negedge wb_clk_i);
    chk_idle("reset");
    chk("reset.itime", integration_time_o, 0);
    chk("reset.result_count", result_count, 0);
    chk("reset.result_bit", result_bit, 0);
    chk("reset.state", state_o, 0);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);

    // Single bit 0, ten RUN cycles, count 123
    start_sweep(3'd0, 3'd0, 32'd10);
    to_run(3'd0, 32'd10, 1'b0);
    finish_run(3'd0, 32'd123, 10, 1'b1);
    @(negedge wb_clk_i);
    chk_idle("single.end");
    repeat (3) @(negedge wb_clk_i);
    chk("hold.result_count", result_count, 123);
    chk("hold.result_bit", result_bit, 0);

    // Sweep 2..5
    t = $urandom_range(1, 50);
    start_sweep(3'd2, 3'd5, t);
    for (int b = 2; b <= 5; b++) begin
      chk("sweep.sel_table", a_input_ring_bit_b, sel_tab[b-2]);
      to_run(3'(b), t, 1'b0);
      finish_run(3'(b), $urandom_range(1, 100000), $urandom_range(1, 6), (b == 5));
      @(negedge wb_clk_i);
    end
    chk_idle("sweep.end");

    // Abort during RUN of bit 3 in a 0..7 sweep
    start_sweep(3'd0, 3'd7, 32'd5);
    for (int b = 0; b < 3; b++) begin
      to_run(3'(b), 32'd5, 1'b0);
      finish_run(3'(b), $urandom_range(1, 1000), $urandom_range(1, 4), 1'b0);
      @(negedge wb_clk_i);
    end
    to_run(3'd3, 32'd5, 1'b0);
    chk("abort.in_run", counter_enable, 1);
    @(negedge wb_clk_i);
    abort = 1'b1;
    done = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    done = 1'b0;
    chk_idle("abort.next");
    chk("abort.state", state_o, 0);
    for (int i = 0; i < 20; i++) begin
      done = 1'($urandom_range(0, 1));
      @(negedge wb_clk_i);
    end
    done = 1'b0;
    chk("abort.stays_idle", busy, 0);

    // Done held through SETTLE, zero integration time, bit 4
    start_sweep(3'd4, 3'd4, 32'd0);
    to_run(3'd4, 32'd0, 1'b1);
    finish_run(3'd4, 32'd777, 1, 1'b1);
    @(negedge wb_clk_i);
    chk_idle("settle_done.end");

    // Reversed range 6..1 with start re-pulsed while busy
    start_sweep(3'd6, 3'd1, 32'd7);
    start = 1'b1;
    bit_first = 3'd2;
    bit_last  = 3'd2;
    to_run(3'd6, 32'd7, 1'b0);
    start = 1'b0;
    finish_run(3'd6, 32'd4242, 2, 1'b1);
    @(negedge wb_clk_i);
    chk_idle("reversed.end");
    repeat (3) @(negedge wb_clk_i);
    chk("reversed.no_restart", busy, 0);

    // Reset pulse during LOAD
    start_sweep(3'd1, 3'd3, 32'd9);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("rst_load.in_load", counter_load, 1);
    wb_rst_ni = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    chk_idle("rst_load");
    chk("rst_load.itime", integration_time_o, 0);
    chk("rst_load.result_count", result_count, 0);
    chk("rst_load.result_bit", result_bit, 0);
    chk("rst_load.state", state_o, 0);
    repeat (5) @(negedge wb_clk_i);
    chk("rst_load.stays_idle", busy, 0);

    // Final report
    chk("scoreboard.empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_measure_sequencer.md
ADDER_MEASURE_SEQUENCER -- requirements
Module: adder_measure_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, ring run cycles before counting begins.
REQ-002 Parameter CNT_W, default 32, width of integration time and ring count.
REQ-003 wb_clk_i  input  1  single clock, also clocks the adder's time counter.
REQ-004 wb_rst_ni  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  begin a bit sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel the sweep from any state.
REQ-007 integration_time_i  input  CNT_W  time window per measurement.
REQ-008 bit_first, bit_last  input  3 each  inclusive sweep range of adder bit indices.
REQ-009 adder_reset, counter_load, counter_enable, stop_b  output  1 each  adder loop/counter controls.
REQ-010 integration_time_o  output  CNT_W  window value driven to the adder.
REQ-011 a_input_ring_bit_b, s_output_bit_b  output  8 each  inverted one-hot ring bit selects.
REQ-012 done  input  1  adder integration counter reached zero.
REQ-013 ring_count_i  input  CNT_W  adder ring-cycle counter.
REQ-014 result_valid  output  1  one-cycle pulse: result_bit/result_count valid.
REQ-015 result_bit  output  3, result_count  output  CNT_W  measured bit and its count.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 sweep_done  output  1  one-cycle pulse at normal sweep completion.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, LOAD, SETTLE, RUN, CAPTURE, NEXT.
REQ-019 IDLE: start=1 latches integration_time_i, bit_first, bit_last, sets cur_bit=bit_first, goes to CLEAR; start while busy is ignored.
REQ-020 CLEAR: adder_reset=1 for exactly 2 cycles, then LOAD.
REQ-021 LOAD: counter_load=1 for exactly 1 cycle, integration_time_o = latched value, then SETTLE.
REQ-022 SETTLE: stop_b=1 for SETTLE_CYCLES cycles, counter_enable=0, then RUN.
REQ-023 RUN: stop_b=1, counter_enable=1 until done sampled high, then CAPTURE; done is ignored in every other state.
REQ-024 CAPTURE: stop_b=0, counter_enable=0, result_count<=ring_count_i, result_bit<=cur_bit, result_valid pulses 1 cycle later in NEXT.
REQ-025 NEXT: if cur_bit==last bit go IDLE with sweep_done pulse same cycle as result_valid; else cur_bit+1 and go CLEAR.
REQ-026 bit_first>bit_last SHALL measure bit_first only (last bit = bit_first).
REQ-027 Selects: a_input_ring_bit_b = s_output_bit_b = ~(8'b1<<cur_bit) in all non-IDLE states; 8'hFF in IDLE.
REQ-028 stop_b SHALL be 0 outside SETTLE and RUN; counter_enable SHALL be 0 outside RUN.
REQ-029 integration_time_i==0 SHALL be legal; RUN exits on the first done.
REQ-030 abort=1 in any state: next cycle IDLE, all controls deasserted, no result_valid or sweep_done; abort wins over simultaneous start/done.
REQ-031 result_bit/result_count SHALL hold their value until the next capture.

Reset
REQ-032 wb_rst_ni=0 at a clock edge: state IDLE, cur_bit 0, adder_reset/counter_load/counter_enable/stop_b 0, selects 8'hFF, integration_time_o 0, result_count 0, result_bit 0, result_valid/sweep_done/busy 0.
REQ-033 Reset mid-sweep SHALL behave as abort and discard the in-flight measurement.

Structure
REQ-034 Package adder_seq_pkg SHALL hold the state enum, CLEAR_CYCLES=2 and the 3-bit bit-index type.
REQ-035 One sub-module, ring_bit_select, SHALL decode cur_bit to the inverted one-hot select; everything else stays in the top.

Verification
REQ-036 start, bits 0..0, time 10, done after 10 RUN cycles, ring_count_i=123 -> one result_valid with bit 0, count 123, sweep_done same cycle.
REQ-037 sweep 2..5 -> four result_valid pulses, bits 2,3,4,5 in order, selects 8'hFB,F7,EF,DF during each.
REQ-038 abort asserted during RUN of bit 3 in sweep 0..7 -> IDLE next cycle, stop_b=0, no further result_valid or sweep_done.
REQ-039 done held high throughout SETTLE -> ignored; RUN still entered, exits on first RUN-cycle done.
REQ-040 bit_first=6, bit_last=1 -> exactly one result with bit 6; start pulsed while busy -> no restart.
REQ-041 wb_rst_ni low for 1 cycle during LOAD -> all outputs at REQ-032 values next cycle.
